// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite slave bridge: response codes, FSM states,
// and a parameter sanity check for the data width.
package axi4l_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } bridge_state_t;

  // Only 32-bit and 64-bit data paths are supported by the bridge.
  function automatic bit data_width_ok(input int unsigned width);
    return (width == 32) || (width == 64);
  endfunction

endpackage

// File: rtl/axi4l_bridge_timeout.sv
// Bus-request watchdog: loaded when a register-bus request starts, cleared
// when it completes, and flags expiry once the request has been outstanding
// for TIMEOUT_CYCLES cycles. Only instantiated when TIMEOUT_CYCLES > 0.
module axi4l_bridge_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic          active;

  // Down-counter: the first request cycle holds TIMEOUT_CYCLES-1, so the
  // count reaches zero during the last permitted request cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      count  <= '0;
    end else if (load) begin
      active <= 1'b1;
      count  <= LOAD_VAL;
    end else if (clear) begin
      active <= 1'b0;
      count  <= '0;
    end else if (active && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = active && (count == '0);

endmodule

// File: rtl/axi4l_slave_bridge.sv
// AXI4-Lite slave that terminates the five AXI channels and runs one
// transaction at a time on the simple register bus (bus_req/bus_ready).
// Write address and data are captured independently; reads and complete
// writes are arbitrated with alternating priority.
module axi4l_slave_bridge
  import axi4l_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic                    bus_req,
  output logic                    bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic [DATA_WIDTH/8-1:0] bus_wr_strobe,
  input  logic                    bus_ready,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("axi4l_slave_bridge: DATA_WIDTH must be 32 or 64");
  end

  bridge_state_t           state;
  logic                    out_en;
  logic                    wr_prio;
  logic                    aw_held;
  logic                    w_held;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;

  logic in_idle, in_rd;
  logic aw_hs, w_hs, ar_hs;
  logic wr_full;
  logic start_wr, start_rd;
  logic req_done;
  logic tmo_expired;

  // Channel readiness, handshakes and arbitration. wr_full includes a
  // handshake completing this cycle, so a write arriving together with a
  // read is arbitrated rather than racing it. out_en keeps all readies low
  // during reset and the first cycle after it.
  always_comb begin
    in_idle   = (state == ST_IDLE);
    in_rd     = (state == ST_RD_REQ) || (state == ST_RD_RESP);
    s_awready = out_en && !aw_held && (in_idle || in_rd);
    s_wready  = out_en && !w_held  && (in_idle || in_rd);
    aw_hs     = s_awvalid && s_awready;
    w_hs      = s_wvalid  && s_wready;
    wr_full   = (aw_held || aw_hs) && (w_held || w_hs);
    s_arready = out_en && in_idle && (!wr_full || !wr_prio);
    ar_hs     = s_arvalid && s_arready;
    start_rd  = ar_hs;
    start_wr  = in_idle && wr_full && !ar_hs;
    req_done  = bus_req && (bus_ready || tmo_expired);
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    axi4l_bridge_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .load   (start_rd || start_wr),
      .clear  (req_done),
      .expired(tmo_expired)
    );
  end else begin : g_no_timeout
    assign tmo_expired = 1'b0;
  end

  // Transaction FSM with holding registers and registered bus/response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      out_en        <= 1'b0;
      wr_prio       <= 1'b1;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bus_req       <= 1'b0;
      bus_req_is_wr <= 1'b0;
      bus_addr      <= '0;
      bus_wr_data   <= '0;
      bus_wr_strobe <= '0;
      s_bvalid      <= 1'b0;
      s_bresp       <= RESP_OKAY;
      s_rvalid      <= 1'b0;
      s_rresp       <= RESP_OKAY;
      s_rdata       <= '0;
    end else begin
      out_en <= 1'b1;

      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end

      case (state)
        ST_IDLE: begin
          if (start_rd) begin
            state         <= ST_RD_REQ;
            bus_req       <= 1'b1;
            bus_req_is_wr <= 1'b0;
            bus_addr      <= s_araddr;
            if (wr_full) wr_prio <= 1'b1;
          end else if (start_wr) begin
            // Holding registers may still be loading this edge, so take
            // the payload from the bypass path when it is not yet held.
            state         <= ST_WR_REQ;
            bus_req       <= 1'b1;
            bus_req_is_wr <= 1'b1;
            bus_addr      <= aw_held ? aw_addr_q : s_awaddr;
            bus_wr_data   <= w_held  ? w_data_q  : s_wdata;
            bus_wr_strobe <= w_held  ? w_strb_q  : s_wstrb;
            if (s_arvalid) wr_prio <= 1'b0;
          end
        end

        ST_WR_REQ: begin
          if (req_done) begin
            bus_req  <= 1'b0;
            state    <= ST_WR_RESP;
            s_bvalid <= 1'b1;
            s_bresp  <= (bus_ready && !bus_err) ? RESP_OKAY : RESP_SLVERR;
          end
        end

        ST_WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        ST_RD_REQ: begin
          if (req_done) begin
            bus_req  <= 1'b0;
            state    <= ST_RD_RESP;
            s_rvalid <= 1'b1;
            if (bus_ready && !bus_err) begin
              s_rresp <= RESP_OKAY;
              s_rdata <= bus_rd_data;
            end else begin
              s_rresp <= RESP_SLVERR;
              s_rdata <= '0;
            end
          end
        end

        ST_RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            s_rresp  <= RESP_OKAY;
            s_rdata  <= '0;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
